// File: rtl/spi_slave_core.sv
// SPI slave: oversampled ss/sclk/mosi, 1..128-bit characters, one-entry TX buffer and RX holding register.
// Defining SPI_SLAVE_IRQ_EN adds the ie input and the registered int_o interrupt output.
module spi_slave_core #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        TX_IDLE     = 1'b0
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_ni,
  input  logic [6:0]   char_len,
  input  logic         lsb,
  input  logic         tx_negedge,
  input  logic         rx_negedge,
  input  logic [127:0] tx_data,
  input  logic         tx_valid,
  output logic         tx_ready,
  output logic [127:0] rx_data,
  output logic         rx_valid,
  input  logic         rx_ack,
  output logic         overrun,
  output logic         frame_err,
  output logic         busy,
`ifdef SPI_SLAVE_IRQ_EN
  input  logic         ie,
  output logic         int_o,
`endif
  input  logic         ss_pad_i,
  input  logic         sclk_pad_i,
  input  logic         mosi_pad_i,
  output logic         miso_pad_o
);
  localparam int unsigned NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_ACTIVE,
    S_DONE
  } state_t;

  logic [NS-1:0] ss_sync_q;
  logic [NS-1:0] sclk_sync_q;
  logic [NS-1:0] mosi_sync_q;
  logic          sclk_dly_q;
  logic          ss_s;
  logic          sclk_s;
  logic          mosi_s;
  logic          sclk_rise;
  logic          sclk_fall;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ss_sync_q   <= '1;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      sclk_dly_q  <= 1'b0;
    end else begin
      ss_sync_q   <= {ss_sync_q[NS-2:0], ss_pad_i};
      sclk_sync_q <= {sclk_sync_q[NS-2:0], sclk_pad_i};
      mosi_sync_q <= {mosi_sync_q[NS-2:0], mosi_pad_i};
      sclk_dly_q  <= sclk_sync_q[NS-1];
    end
  end

  assign ss_s      = ss_sync_q[NS-1];
  assign sclk_s    = sclk_sync_q[NS-1];
  assign mosi_s    = mosi_sync_q[NS-1];
  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign sclk_fall = ~sclk_s & sclk_dly_q;

  function automatic logic [127:0] len_mask(input logic [7:0] len);
    logic [127:0] m;
    m = '0;
    for (int i = 0; i < 128; i++) begin
      m[i] = (i < int'(len));
    end
    return m;
  endfunction

  state_t         state_q, state_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [7:0]     len_q, len_d;
  logic           lsb_q, lsb_d;
  logic           txneg_q, txneg_d;
  logic           rxneg_q, rxneg_d;
  logic           first_q, first_d;
  logic [127:0]   tx_sh_q, tx_sh_d;
  logic [127:0]   rx_sh_q, rx_sh_d;
  logic [127:0]   txbuf_q, txbuf_d;
  logic           txbuf_full_q, txbuf_full_d;
  logic [127:0]   rx_data_q, rx_data_d;
  logic           rx_valid_q, rx_valid_d;
  logic           overrun_q, overrun_d;
  logic           frame_err_q, frame_err_d;
  logic           miso_q, miso_d;

  logic [7:0]     len_in;
  logic [127:0]   tx_src;
  logic [7:0]     cnt_inc;
  logic           samp;
  logic           launch;

  assign len_in  = (char_len == 7'd0) ? 8'd128 : {1'b0, char_len};
  assign tx_src  = txbuf_full_q ? txbuf_q : {128{TX_IDLE}};
  assign cnt_inc = cnt_q + 8'd1;
  assign samp    = rxneg_q ? sclk_fall : sclk_rise;
  assign launch  = txneg_q ? sclk_fall : sclk_rise;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    lsb_d        = lsb_q;
    txneg_d      = txneg_q;
    rxneg_d      = rxneg_q;
    first_d      = first_q;
    tx_sh_d      = tx_sh_q;
    rx_sh_d      = rx_sh_q;
    txbuf_d      = txbuf_q;
    txbuf_full_d = txbuf_full_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    overrun_d    = overrun_q;
    frame_err_d  = 1'b0;
    miso_d       = miso_q;

    if (tx_valid && !txbuf_full_q) begin
      txbuf_d      = tx_data;
      txbuf_full_d = 1'b1;
    end
    if (rx_ack) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        miso_d = TX_IDLE;
        if (!ss_s) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (ss_s) begin
          state_d = S_IDLE;
          miso_d  = TX_IDLE;
        end else begin
          len_d        = len_in;
          lsb_d        = lsb;
          txneg_d      = tx_negedge;
          rxneg_d      = rx_negedge;
          tx_sh_d      = tx_src;
          rx_sh_d      = '0;
          cnt_d        = 8'd0;
          first_d      = 1'b0;
          txbuf_full_d = 1'b0;
          miso_d       = lsb ? tx_src[0] : tx_src[7'(len_in - 8'd1)];
          state_d      = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (ss_s) begin
          // A partially shifted character is dropped; only a started one is an error.
          frame_err_d = (cnt_q != 8'd0);
          miso_d      = TX_IDLE;
          state_d     = S_IDLE;
        end else begin
          if (samp) begin
            if (lsb_q) begin
              rx_sh_d                     = rx_sh_q >> 1;
              rx_sh_d[7'(len_q - 8'd1)]   = mosi_s;
            end else begin
              rx_sh_d = {rx_sh_q[126:0], mosi_s};
            end
            cnt_d   = cnt_inc;
            first_d = 1'b1;
            if (cnt_inc == len_q) state_d = S_DONE;
          end
          // The first bit is already on miso from LOAD, so the launch edge only
          // advances once the master has sampled at least once.
          if (launch && first_q) begin
            if (lsb_q) begin
              tx_sh_d = tx_sh_q >> 1;
              miso_d  = tx_sh_q[1];
            end else begin
              tx_sh_d = tx_sh_q << 1;
              miso_d  = tx_sh_q[7'(len_q - 8'd2)];
            end
          end
        end
      end
      S_DONE: begin
        rx_data_d  = rx_sh_q & len_mask(len_q);
        rx_valid_d = 1'b1;
        if (rx_valid_q && !rx_ack) overrun_d = 1'b1;
        if (ss_s) begin
          state_d = S_IDLE;
          miso_d  = TX_IDLE;
        end else begin
          state_d = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q      <= S_IDLE;
      cnt_q        <= 8'd0;
      len_q        <= 8'd8;
      lsb_q        <= 1'b0;
      txneg_q      <= 1'b0;
      rxneg_q      <= 1'b0;
      first_q      <= 1'b0;
      tx_sh_q      <= '0;
      rx_sh_q      <= '0;
      txbuf_q      <= '0;
      txbuf_full_q <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      miso_q       <= TX_IDLE;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      lsb_q        <= lsb_d;
      txneg_q      <= txneg_d;
      rxneg_q      <= rxneg_d;
      first_q      <= first_d;
      tx_sh_q      <= tx_sh_d;
      rx_sh_q      <= rx_sh_d;
      txbuf_q      <= txbuf_d;
      txbuf_full_q <= txbuf_full_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      overrun_q    <= overrun_d;
      frame_err_q  <= frame_err_d;
      miso_q       <= miso_d;
    end
  end

  assign tx_ready   = ~txbuf_full_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign overrun    = overrun_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != S_IDLE);
  assign miso_pad_o = miso_q;

`ifdef SPI_SLAVE_IRQ_EN
  logic int_q;

  // Built from next-state flags so rx_ack drops the interrupt on the following cycle.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      int_q <= 1'b0;
    end else begin
      int_q <= ie && (rx_valid_d || overrun_d);
    end
  end

  assign int_o = int_q;
`endif

endmodule

// File: tb/tb_spi_slave_core.sv
// Bench for spi_slave_core: bench-side SPI master plus a frame-level model of the slave's visible state.
module tb_spi_slave_core;
  localparam logic TXI  = 1'b0;
  localparam int   HALF = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [6:0]   char_len = 7'd8;
  logic         lsb = 1'b0;
  logic         tx_negedge = 1'b0;
  logic         rx_negedge = 1'b1;
  logic [127:0] tx_data = '0;
  logic         tx_valid = 1'b0;
  logic         tx_ready;
  logic [127:0] rx_data;
  logic         rx_valid;
  logic         rx_ack = 1'b0;
  logic         overrun;
  logic         frame_err;
  logic         busy;
  logic         ss = 1'b1;
  logic         sclk = 1'b0;
  logic         mosi = 1'b0;
  logic         miso;
`ifdef SPI_SLAVE_IRQ_EN
  logic         ie = 1'b0;
  logic         int_o;
`endif

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;

  logic         steady = 1'b0;
  logic         exp_rx_valid = 1'b0;
  logic         exp_overrun = 1'b0;
  logic         exp_tx_ready = 1'b1;
  logic [127:0] exp_rx_data = '0;
  logic [127:0] exp_tx_word = '0;
  logic [127:0] got;
  logic [127:0] got2;

  always #5 clk = ~clk;

  spi_slave_core #(.SYNC_STAGES(2), .TX_IDLE(TXI)) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .char_len  (char_len),
    .lsb       (lsb),
    .tx_negedge(tx_negedge),
    .rx_negedge(rx_negedge),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ack    (rx_ack),
    .overrun   (overrun),
    .frame_err (frame_err),
    .busy      (busy),
`ifdef SPI_SLAVE_IRQ_EN
    .ie        (ie),
    .int_o     (int_o),
`endif
    .ss_pad_i  (ss),
    .sclk_pad_i(sclk),
    .mosi_pad_i(mosi),
    .miso_pad_o(miso)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] mask_n(input int n);
    return (n >= 128) ? {128{1'b1}} : ((128'd1 << n) - 128'd1);
  endfunction

  // Outside frames the slave's visible state must match the model every cycle.
  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_cnt++;
    if (steady) begin
      chk("cmp_rx_valid", rx_valid, exp_rx_valid);
      chk("cmp_rx_data", rx_data, exp_rx_data);
      chk("cmp_overrun", overrun, exp_overrun);
      chk("cmp_tx_ready", tx_ready, exp_tx_ready);
      chk("cmp_busy", busy, 1'b0);
      chk("cmp_frame_err", frame_err, 1'b0);
      chk("cmp_miso_idle", miso, TXI);
    end
  end

  task automatic half();
    repeat (HALF) @(negedge clk);
  endtask

  task automatic cfg(input int n, input logic lf, input logic mln);
    char_len   = 7'(n);
    lsb        = lf;
    tx_negedge = mln;
    rx_negedge = ~mln;
  endtask

  // One character as seen by the slave, and what the master should get back.
  task automatic model_char(input int n, input logic [127:0] sent, output logic [127:0] eg);
    logic [127:0] m;
    m = mask_n(n);
    eg = exp_tx_ready ? ({128{TXI}} & m) : (exp_tx_word & m);
    exp_tx_ready = 1'b1;
    if (exp_rx_valid) exp_overrun = 1'b1;
    exp_rx_valid = 1'b1;
    exp_rx_data  = sent & m;
  endtask

  task automatic shift_char(input int n, input logic lf, input logic mln, input logic [127:0] send,
                            input int nb, output logic [127:0] rcv);
    int   idx;
    logic b;
    rcv = '0;
    for (int i = 0; i < nb; i++) begin
      idx  = lf ? i : n - 1 - i;
      mosi = send[idx];
      if (!mln) begin
        sclk = 1'b1;
        half();
        b    = miso;
        sclk = 1'b0;
        half();
      end else begin
        half();
        b    = miso;
        sclk = 1'b1;
        half();
        sclk = 1'b0;
      end
      rcv[idx] = b;
    end
  endtask

  task automatic frame(input int n, input logic lf, input logic mln, input logic [127:0] send,
                       output logic [127:0] rcv);
    logic [127:0] eg;
    steady = 1'b0;
    ss = 1'b0;
    half();
    chk("busy_in_frame", busy, 1'b1);
    shift_char(n, lf, mln, send, n, rcv);
    half();
    ss = 1'b1;
    half();
    model_char(n, send, eg);
    chk("model_mst_rx", rcv, eg);
    steady = 1'b1;
  endtask

  task automatic load_tx(input logic [127:0] v);
    steady   = 1'b0;
    tx_data  = v;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid     = 1'b0;
    exp_tx_word  = v;
    exp_tx_ready = 1'b0;
    steady       = 1'b1;
  endtask

  task automatic ack();
    steady = 1'b0;
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack       = 1'b0;
    exp_rx_valid = 1'b0;
    exp_overrun  = 1'b0;
    steady       = 1'b1;
  endtask

  initial begin
    logic [127:0] eg1;
    logic [127:0] eg2;
    int           fe_before;

    repeat (3) @(negedge clk);
    chk("rst_tx_ready", tx_ready, 1'b1);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_rx_data", rx_data, 128'd0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_miso", miso, TXI);
    rst_n  = 1'b1;
    steady = 1'b1;
    repeat (4) @(negedge clk);

    // 8-bit MSB first, slave launches on rise and samples on fall
    cfg(8, 1'b0, 1'b0);
    load_tx(128'h5a);
    repeat (3) @(negedge clk);
    frame(8, 1'b0, 1'b0, 128'ha5, got);
    chk("t1_mst_rx", got, 128'h5a);
    chk("t1_rx_data", rx_data, 128'ha5);
    chk("t1_rx_valid", rx_valid, 1'b1);
    chk("t1_tx_ready", tx_ready, 1'b1);
    ack();

    // 16-bit LSB first, slave launches on fall and samples on rise
    cfg(16, 1'b1, 1'b1);
    load_tx(128'ha55a);
    frame(16, 1'b1, 1'b1, 128'h5aa5, got);
    chk("t2_mst_rx", got, 128'ha55a);
    chk("t2_rx_data", rx_data, 128'h5aa5);
    ack();

    // 128-bit character, nothing loaded for TX
    cfg(128, 1'b0, 1'b0);
    frame(128, 1'b0, 1'b0, 128'h00112233_44556677_8899aabb_ccddeeff, got);
    chk("t3_mst_rx", got, 128'd0);
    chk("t3_rx_data", rx_data, 128'h00112233_44556677_8899aabb_ccddeeff);
    ack();

    // two 32-bit characters under one ss low, no ack in between
    cfg(32, 1'b0, 1'b0);
    steady = 1'b0;
    ss = 1'b0;
    half();
    shift_char(32, 1'b0, 1'b0, 128'hdeadbeef, 32, got);
    shift_char(32, 1'b0, 1'b0, 128'h01248421, 32, got2);
    half();
    ss = 1'b1;
    half();
    model_char(32, 128'hdeadbeef, eg1);
    model_char(32, 128'h01248421, eg2);
    chk("b2b_mst_rx1", got, eg1);
    chk("b2b_mst_rx2", got2, eg2);
    steady = 1'b1;
    chk("b2b_rx_data", rx_data, 128'h01248421);
    chk("b2b_overrun", overrun, 1'b1);
    chk("b2b_rx_valid", rx_valid, 1'b1);
    ack();
    chk("b2b_ack_valid", rx_valid, 1'b0);
    chk("b2b_ack_overrun", overrun, 1'b0);

    // ss released after 5 of 8 bits
    cfg(8, 1'b0, 1'b0);
    fe_before = fe_cnt;
    steady = 1'b0;
    ss = 1'b0;
    half();
    shift_char(8, 1'b0, 1'b0, 128'hff, 5, got);
    half();
    ss = 1'b1;
    half();
    steady = 1'b1;
    chk("fe_pulse_cycles", 128'(fe_cnt - fe_before), 128'd1);
    chk("fe_rx_valid", rx_valid, 1'b0);
    frame(8, 1'b0, 1'b0, 128'h3c, got);
    chk("fe_next_rx_data", rx_data, 128'h3c);
    chk("fe_no_new_pulse", 128'(fe_cnt - fe_before), 128'd1);

    // asynchronous reset in the middle of a frame, TX buffer full, rx_valid set
    steady = 1'b0;
    ss = 1'b0;
    half();
    tx_data  = 128'h81;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("mid_tx_ready", tx_ready, 1'b0);
    shift_char(8, 1'b0, 1'b0, 128'h96, 3, got);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_tx_ready", tx_ready, 1'b1);
    chk("arst_rx_valid", rx_valid, 1'b0);
    chk("arst_rx_data", rx_data, 128'd0);
    chk("arst_overrun", overrun, 1'b0);
    chk("arst_frame_err", frame_err, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_miso", miso, TXI);
    ss   = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    repeat (3) @(negedge clk);
    rst_n        = 1'b1;
    exp_rx_valid = 1'b0;
    exp_rx_data  = '0;
    exp_overrun  = 1'b0;
    exp_tx_ready = 1'b1;
    steady       = 1'b1;
    repeat (6) @(negedge clk);

`ifdef SPI_SLAVE_IRQ_EN
    begin
      logic found;
      ie = 1'b1;
      cfg(1, 1'b0, 1'b0);
      steady = 1'b0;
      ss = 1'b0;
      half();
      mosi = 1'b1;
      sclk = 1'b1;
      half();
      sclk = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 32 && !found; k++) begin
        @(negedge clk);
        if (rx_valid) found = 1'b1;
      end
      chk("irq_rx_valid_seen", found, 1'b1);
      chk("irq_int_set", int_o, 1'b1);
      chk("irq_rx_data", rx_data, 128'h1);
      half();
      ss = 1'b1;
      half();
      rx_ack = 1'b1;
      @(negedge clk);
      rx_ack = 1'b0;
      chk("irq_int_clr", int_o, 1'b0);
      chk("irq_rx_valid_clr", rx_valid, 1'b0);
      exp_rx_valid = 1'b0;
      exp_rx_data  = 128'h1;
      exp_overrun  = 1'b0;
      steady       = 1'b1;
      repeat (4) @(negedge clk);
    end
`endif

    steady = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog got=timeout want=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/spi_slave_core.md
Name: spi_slave_core

Overview:
Synthesizable SPI slave: the far end of the SPI link driven by spi_top.
- Oversamples ss/sclk/mosi in the system clock domain and shifts up to 128-bit characters.
- Uses the same character-length, bit-order and edge conventions as the master's CTRL register.
- Exposes a parallel TX buffer and RX holding register with simple valid/ready handshakes to local logic.
- Used as on-chip peripheral endpoint and as a synthesizable replacement for the behavioural slave model in loopback benches.

Parameters:
SYNC_STAGES, 2, synchronizer flops on ss_pad_i/sclk_pad_i/mosi_pad_i (min 2)
TX_IDLE, 1'b0, miso value shifted out when no TX word was loaded for the frame

Ports:
wb_clk_i  in  1  system clock; sclk must be <= wb_clk_i/8
wb_rst_ni  in  1  asynchronous active-low reset
char_len  in  7  bits per character; 0 = 128
lsb  in  1  1 = LSB first, 0 = MSB first
tx_negedge  in  1  1 = launch miso on falling sclk, 0 = rising
rx_negedge  in  1  1 = sample mosi on falling sclk, 0 = rising
tx_data  in  128  word to transmit
tx_valid  in  1  tx_data offered
tx_ready  out  1  TX buffer empty; transfer when tx_valid && tx_ready
rx_data  out  128  last received character, right-aligned
rx_valid  out  1  rx_data holds an unread character
rx_ack  in  1  consumes rx_data; clears rx_valid
overrun  out  1  sticky: character completed while rx_valid=1; cleared by rx_ack
frame_err  out  1  one-cycle pulse: ss deasserted mid-character
busy  out  1  frame in progress (synced ss low)
ss_pad_i  in  1  slave select, active low
sclk_pad_i  in  1  serial clock
mosi_pad_i  in  1  master out
miso_pad_o  out  1  slave out

Behaviour:
- Reset (async, wb_rst_ni=0): tx_ready=1, rx_valid=0, rx_data=0, overrun=0, frame_err=0, busy=0, miso_pad_o=TX_IDLE, bit counter 0, state IDLE. Synchronizers reset to ss=1, sclk=0, mosi=0.
- Synchronization: pads pass SYNC_STAGES flops; one extra flop on sclk gives rise/fall edge strobes. Pad-to-action latency is SYNC_STAGES+1 cycles.
- TX buffer: one entry. Load when tx_valid && tx_ready (tx_ready drops next cycle). Copied to the TX shift register at each character start, then tx_ready=1 the next cycle.
- States:
  - IDLE: synced ss falling -> LOAD.
  - LOAD (1 cycle): TX shift <= buffer, or all TX_IDLE if the buffer is empty; cnt=0; first_sample=0; miso_pad_o = first bit (bit[len-1] if lsb=0, else bit0) -> ACTIVE.
  - ACTIVE, sample edge (per rx_negedge): RX shift takes mosi (into bit0 shifting up if lsb=0; into bit len-1 shifting down if lsb=1); cnt++; first_sample=1. When cnt reaches len -> DONE.
  - ACTIVE, launch edge (per tx_negedge): if first_sample=1, shift TX and drive the next bit; launch edges before the first sample of a character are ignored.
  - DONE (1 cycle): rx_data <= RX shift masked to len bits; rx_valid=1; overrun set if rx_valid was already 1 (new data overwrites). If ss still low -> LOAD (back-to-back character); else IDLE.
- Any state, synced ss rising before cnt reaches len and cnt != 0: frame_err pulse, partial discarded, rx_valid untouched -> IDLE. ss rising with cnt==0 -> IDLE silently.
- rx_ack in the same cycle as DONE: new data kept, rx_valid stays 1, no overrun.
- busy = state != IDLE. miso_pad_o returns to TX_IDLE in IDLE.
- char_len/lsb/edge inputs are sampled in LOAD; changes mid-character take effect at the next character.

Optional Feature:
SPI_SLAVE_IRQ_EN:
- Defined: adds ports ie (in 1) and int_o (out 1). int_o = ie && (rx_valid || overrun), registered; reset 0; cleared by rx_ack next cycle.
- Undefined: neither port exists; no interrupt logic.

Test Plan:
- 8-bit, MSB first, master launches posedge/samples negedge (slave tx_negedge=0, rx_negedge=1); tx_data=0x5a preloaded; master sends 0xa5 -> master receives 0x5a; rx_data=0xa5; rx_valid=1; tx_ready=1.
- 16-bit, LSB first, tx_negedge=1, rx_negedge=0; slave tx 0xa55a; master sends 0x5aa5 -> rx_data=0x5aa5; master receives 0xa55a.
- 128-bit (char_len=0), MSB first; master sends 0x00112233_44556677_8899aabb_ccddeeff -> rx_data equals it bit-exact; no TX loaded, so master receives all TX_IDLE (0).
- Two back-to-back 32-bit characters under one ss low, rx_ack withheld -> second char 0x01248421 in rx_data; overrun=1; rx_ack clears rx_valid and overrun.
- ss deasserted after 5 of 8 bits -> frame_err single-cycle pulse; rx_valid stays 0; next full 8-bit frame 0x3c received correctly. Assert wb_rst_ni mid-frame -> all outputs at reset values immediately.
- With SPI_SLAVE_IRQ_EN, ie=1, 1-bit char mosi=1 -> rx_data=0x1; int_o=1 one cycle after DONE; int_o=0 the cycle after rx_ack.
